// File: rtl/mem_pkg.sv
// Shared definitions for the pipelined memory controller and its response FIFO.
package mem_pkg;

    // Upper bound on the configurable read latency.
    localparam int unsigned RD_LAT_MAX = 4;

    // Width of a counter able to hold the values 0..depth inclusive.
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // One byte lane of a byte-enable write merge.
    function automatic logic [7:0] lane_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       en);
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Synchronous response FIFO with occupancy count and asynchronous reset.
module mem_resp_fifo
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [occ_w(DEPTH)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = occ_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rd_ptr];

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_ctrl_pipe.sv
// Pipelined single-port memory controller: byte-enable writes, fixed read
// latency, in-order responses and credit-based request flow control.
module mem_ctrl_pipe
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_write,
    output logic [DATA_W-1:0]   resp_rdata
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned WORDS = 2 ** ADDR_W;
    localparam int unsigned OCC_W = occ_w(RESP_DEPTH);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(RESP_DEPTH);

    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;
    logic              accept;

    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_w;
    logic [DATA_W-1:0] pipe_d [RD_LAT];
    logic              retire;

    logic [OCC_W-1:0]  in_flight;
    logic [OCC_W-1:0]  fifo_count;
    logic [OCC_W-1:0]  occupancy;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_dout;

    assign rd_word   = mem[req_addr];
    // Occupancy is the sum of two registered counts, so req_ready never
    // depends combinationally on req_valid or resp_ready.
    assign occupancy = in_flight + fifo_count;
    assign req_ready = (occupancy < OCC_MAX);
    assign accept    = req_valid && req_ready;
    assign retire    = pipe_v[RD_LAT-1];

    // Byte-lane merge of write data over the currently stored word.
    always_comb begin
        merged = rd_word;
        for (int unsigned b = 0; b < BE_W; b++) begin
            merged[b*8 +: 8] = lane_merge(rd_word[b*8 +: 8], req_wdata[b*8 +: 8], req_be[b]);
        end
    end

    // Storage array: contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && req_write) mem[req_addr] <= merged;
    end

    // Latency pipe carrying {valid, is_write, data}; reads capture the word at the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            pipe_w <= '0;
            for (int unsigned s = 0; s < RD_LAT; s++) pipe_d[s] <= '0;
        end else begin
            pipe_v[0] <= accept;
            pipe_w[0] <= req_write;
            pipe_d[0] <= req_write ? '0 : rd_word;
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                pipe_v[s] <= pipe_v[s-1];
                pipe_w[s] <= pipe_w[s-1];
                pipe_d[s] <= pipe_d[s-1];
            end
        end
    end

    // Credit counter for requests still travelling through the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   in_flight <= in_flight + OCC_W'(1);
                2'b01:   in_flight <= in_flight - OCC_W'(1);
                default: ;
            endcase
        end
    end

    mem_resp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (retire && !fifo_full),
        .din   ({pipe_w[RD_LAT-1], pipe_d[RD_LAT-1]}),
        .pop   (resp_valid && resp_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign resp_valid = !fifo_empty;
    assign resp_write = resp_valid & fifo_dout[DATA_W];
    assign resp_rdata = resp_valid ? fifo_dout[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_mem_ctrl_pipe.sv
// Randomised and directed bench for mem_ctrl_pipe against a transaction-level model.
module tb_mem_ctrl_pipe;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_write;
    logic [31:0] resp_rdata;

    mem_ctrl_pipe #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .RD_LAT     (RD_LAT),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_write (resp_write),
        .resp_rdata (resp_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected response: kind, data and the first edge count at which it is visible.
    typedef struct { logic w; logic [31:0] d; int rdy; } resp_t;
    typedef struct { logic w; logic [31:0] d; } got_t;

    resp_t       exp_q[$];
    got_t        got_q[$];
    logic [31:0] mem_m [16];

    int n_err    = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle starting and ending at a falling edge.
    task automatic cycle(input logic v, input logic w, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input logic rr, output logic acc);
        logic        e_rdy, e_rv, e_w, pop;
        logic [31:0] e_d, mask;
        int          now;
        got_t        g;
        now   = cyc;
        e_rdy = exp_q.size() < DEPTH;
        e_rv  = (exp_q.size() > 0) && (exp_q[0].rdy <= now);
        e_w   = e_rv ? exp_q[0].w : 1'b0;
        e_d   = e_rv ? exp_q[0].d : 32'h0;
        chk("req_ready",  32'(req_ready),  32'(e_rdy));
        chk("resp_valid", 32'(resp_valid), 32'(e_rv));
        chk("resp_write", 32'(resp_write), 32'(e_w));
        chk("resp_rdata", resp_rdata, e_d);
        g.w = resp_write;
        g.d = resp_rdata;
        req_valid  = v;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_be     = be;
        resp_ready = rr;
        acc = v && e_rdy;
        pop = e_rv && rr;
        @(posedge clk);
        if (pop) begin
            got_q.push_back(g);
            void'(exp_q.pop_front());
        end
        if (acc) begin
            if (w) begin
                mask = 32'h0;
                for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
                mem_m[a] = (mem_m[a] & ~mask) | (d & mask);
                exp_q.push_back('{1'b1, 32'h0, now + 1 + RD_LAT});
            end else begin
                exp_q.push_back('{1'b0, mem_m[a], now + 1 + RD_LAT});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, acc);
    endtask

    logic        acc;
    logic [31:0] rd_tbl [6];
    logic [3:0]  a_tbl  [6];
    int          k;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; resp_ready = 1'b0;
        #3;
        chk("reset_req_ready",  32'(req_ready),  32'h1);
        chk("reset_resp_valid", 32'(resp_valid), 32'h0);
        chk("reset_resp_write", 32'(resp_write), 32'h0);
        chk("reset_resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Write then read back-to-back.
        got_q.delete();
        cycle(1'b1, 1'b1, 4'd0, 32'h0000000A, 4'hF, 1'b1, acc); chk("b2b_acc0", 32'(acc), 32'h1);
        cycle(1'b1, 1'b1, 4'd1, 32'h00000014, 4'hF, 1'b1, acc); chk("b2b_acc1", 32'(acc), 32'h1);
        cycle(1'b1, 1'b1, 4'd2, 32'h0000001E, 4'hF, 1'b1, acc); chk("b2b_acc2", 32'(acc), 32'h1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'(i), 32'h0, 4'h0, 1'b1, acc);
        idle(6);
        chk("wr_rd_count", 32'(got_q.size()), 32'd6);
        rd_tbl[0] = 32'h0A; rd_tbl[1] = 32'h14; rd_tbl[2] = 32'h1E;
        if (got_q.size() == 6) begin
            for (int i = 0; i < 3; i++) begin
                chk("wr_ack_kind", 32'(got_q[i].w), 32'h1);
                chk("wr_ack_data", got_q[i].d, 32'h0);
                chk("rd_kind", 32'(got_q[i+3].w), 32'h0);
                chk("rd_data", got_q[i+3].d, rd_tbl[i]);
            end
        end

        // Byte enables.
        got_q.delete();
        cycle(1'b1, 1'b1, 4'd5, 32'hAABBCCDD, 4'hF,    1'b1, acc);
        cycle(1'b1, 1'b1, 4'd5, 32'h11223344, 4'b0101, 1'b1, acc);
        cycle(1'b1, 1'b0, 4'd5, 32'h0,        4'h0,    1'b1, acc);
        idle(5);
        chk("be_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) chk("be_merge", got_q[2].d, 32'hAA22CC44);

        // Back-pressure: six held reads with the consumer stalled.
        got_q.delete();
        a_tbl[0] = 4'd0; a_tbl[1] = 4'd1; a_tbl[2] = 4'd2;
        a_tbl[3] = 4'd0; a_tbl[4] = 4'd1; a_tbl[5] = 4'd2;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, a_tbl[k], 32'h0, 4'h0, 1'b0, acc);
            if (acc) k++;
        end
        chk("bp_accepted", 32'(k), 32'd4);
        // Full: the pop edge cannot also accept; the next edge does both.
        cycle(1'b1, 1'b0, a_tbl[k], 32'h0, 4'h0, 1'b1, acc);
        chk("full_no_accept", 32'(acc), 32'h0);
        cycle(1'b1, 1'b0, a_tbl[k], 32'h0, 4'h0, 1'b1, acc);
        chk("push_pop_accept", 32'(acc), 32'h1);
        if (acc) k++;
        for (int i = 0; i < 20 && k < 6; i++) begin
            cycle(1'b1, 1'b0, a_tbl[k], 32'h0, 4'h0, 1'b1, acc);
            if (acc) k++;
        end
        chk("bp_all_accepted", 32'(k), 32'd6);
        idle(8);
        chk("bp_count", 32'(got_q.size()), 32'd6);
        if (got_q.size() == 6)
            for (int i = 0; i < 6; i++) chk("bp_order", got_q[i].d, rd_tbl[i % 3]);

        // Read-after-write on consecutive edges.
        got_q.delete();
        cycle(1'b1, 1'b1, 4'd3, 32'h00000055, 4'hF, 1'b1, acc);
        cycle(1'b1, 1'b0, 4'd3, 32'h0,        4'h0, 1'b1, acc);
        idle(5);
        chk("raw_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) chk("raw_data", got_q[1].d, 32'h55);

        // Reset with two responses buffered and two in flight.
        got_q.delete();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'(i), 32'h0, 4'h0, 1'b0, acc);
        chk("pre_rst_valid", 32'(resp_valid), 32'h1);
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rst_async_valid", 32'(resp_valid), 32'h0);
        chk("rst_async_ready", 32'(req_ready),  32'h1);
        chk("rst_async_rdata", resp_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        idle(6);
        chk("rst_no_stale", 32'(got_q.size()), 32'd0);
        cycle(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, acc);
        chk("rst_first_accept", 32'(acc), 32'h1);
        idle(5);
        chk("rst_mem_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("rst_mem_kept", got_q[0].d, 32'h0A);

        // Randomised traffic against the model.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 4'(i), $urandom, 4'hF, 1'b1, acc);
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, 1'($urandom), 4'($urandom_range(0, 15)),
                  $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 6, acc);
        end
        idle(10);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
